// File: rtl/i2c_chk_pkg.sv
// Purpose: shared types and constants for the I2C bus checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_chk_pkg;

  // Protocol tracking state: outside a transfer, collecting data bits, or waiting for the ACK slot.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BITS = 2'd1,
    ACK  = 2'd2
  } chk_state_t;

  // Width of the sticky error vector.
  localparam int ERR_W = 4;

  // Bit positions inside err_o.
  localparam int ERR_PARTIAL    = 0;
  localparam int ERR_TIMEOUT    = 1;
  localparam int ERR_IDLE_SCL   = 2;
  localparam int ERR_GLITCH     = 3;

endpackage

// File: rtl/i2c_chk_sync.sv
// Purpose: synchronise one raw bus line, optionally filter it, and keep a one-cycle history for edge detection.
// Latency: SYNC_STAGES cycles to o_cur (+2 with I2C_CHK_GLITCH_FILTER_EN defined), o_prev one cycle behind.
// Backpressure: none; passive sampler.
module i2c_chk_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_cur,
  output logic o_prev,
  output logic o_glitch
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_synced;
  logic                   w_filt;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Metastability chain; resets to 1 because an idle I2C bus is pulled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
    end
  end

`ifdef I2C_CHK_GLITCH_FILTER_EN
  logic r_f0;
  logic r_f1;
  logic r_hold;
  logic w_agree;

  // The output only moves once three consecutive samples agree (current plus two stored).
  assign w_agree  = (w_synced == r_f0) && (r_f0 == r_f1);
  assign w_filt   = w_agree ? w_synced : r_hold;
  // A deviating run that collapses back to the held level before being accepted is a rejected glitch.
  assign o_glitch = (r_f0 != r_hold) && (w_synced == r_hold);

  // Sample history and held filter output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f0   <= 1'b1;
      r_f1   <= 1'b1;
      r_hold <= 1'b1;
    end else begin
      r_f0   <= w_synced;
      r_f1   <= r_f0;
      r_hold <= w_filt;
    end
  end
`else
  assign w_filt   = w_synced;
  assign o_glitch = 1'b0;
`endif

  // Previous sample, used by the parent to find edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= w_filt;
    end
  end

  assign o_cur  = w_filt;
  assign o_prev = r_prev;

endmodule

// File: rtl/i2c_bus_checker.sv
// Purpose: passive I2C monitor decoding START/STOP/bits/bytes/ACK and keeping sticky protocol error flags.
// Latency: SYNC_STAGES+1 cycles from pin change to event pulse (+2 with I2C_CHK_GLITCH_FILTER_EN).
// Backpressure: none; every event is a single-cycle pulse that the consumer must take when it appears.
module i2c_bus_checker
  import i2c_chk_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  input  logic             clear_i,
  output logic             busy_o,
  output logic             start_o,
  output logic             rstart_o,
  output logic             stop_o,
  output logic             bit_valid_o,
  output logic             bit_o,
  output logic             byte_valid_o,
  output logic [7:0]       byte_o,
  output logic             ack_valid_o,
  output logic             ack_o,
  output logic [ERR_W-1:0] err_o
);

  localparam int            TW    = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_SAT = TW'(TIMEOUT_CYCLES + 1);

  logic w_scl, w_scl_q, w_scl_glitch;
  logic w_sda, w_sda_q, w_sda_glitch;

  i2c_chk_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_line   (scl_i),
    .o_cur    (w_scl),
    .o_prev   (w_scl_q),
    .o_glitch (w_scl_glitch)
  );

  i2c_chk_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_line   (sda_i),
    .o_cur    (w_sda),
    .o_prev   (w_sda_q),
    .o_glitch (w_sda_glitch)
  );

  // Bus conditions. START/STOP need SCL stable high, so a simultaneous SCL edge excludes them.
  logic w_start, w_stop, w_scl_rise, w_scl_fall, w_commit, w_busy;
  assign w_start    = w_sda_q & ~w_sda & w_scl & w_scl_q;
  assign w_stop     = ~w_sda_q & w_sda & w_scl & w_scl_q;
  assign w_scl_rise = w_scl & ~w_scl_q;
  assign w_scl_fall = ~w_scl & w_scl_q;

  chk_state_t    r_state, w_state_nxt;
  logic [2:0]    r_cnt, w_cnt_nxt;
  logic          r_pend, r_sample;
  logic [6:0]    r_shift;
  logic [TW-1:0] r_low;

  logic       r_start, r_rstart, r_stop, r_bit_vld, r_bit, r_byte_vld, r_ack_vld, r_ack;
  logic [7:0] r_byte;
  logic [ERR_W-1:0] r_err, w_err_set;

  logic w_start_p, w_rstart_p, w_stop_p, w_bit_p, w_byte_p, w_ack_p, w_partial, w_idle_scl;

  assign w_busy   = (r_state != IDLE);
  assign w_commit = w_scl_fall & r_pend;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, event pulses and protocol-error detection; STOP beats START, both beat bit commits.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start_p   = 1'b0;
    w_rstart_p  = 1'b0;
    w_stop_p    = 1'b0;
    w_bit_p     = 1'b0;
    w_byte_p    = 1'b0;
    w_ack_p     = 1'b0;
    w_partial   = 1'b0;
    w_idle_scl  = 1'b0;
    if (w_stop) begin
      w_stop_p    = 1'b1;
      w_partial   = (r_state == ACK) || ((r_state == BITS) && (r_cnt != 3'd0));
      w_state_nxt = IDLE;
      w_cnt_nxt   = 3'd0;
    end else if (w_start) begin
      w_start_p   = 1'b1;
      w_rstart_p  = (r_state != IDLE);
      w_partial   = (r_state == ACK) || ((r_state == BITS) && (r_cnt != 3'd0));
      w_state_nxt = BITS;
      w_cnt_nxt   = 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_idle_scl = w_scl_fall;
        end
        BITS: begin
          if (w_commit) begin
            w_bit_p = 1'b1;
            if (r_cnt == 3'd7) begin
              w_byte_p    = 1'b1;
              w_cnt_nxt   = 3'd0;
              w_state_nxt = ACK;
            end else begin
              w_cnt_nxt = r_cnt + 3'd1;
            end
          end
        end
        ACK: begin
          if (w_commit) begin
            w_ack_p     = 1'b1;
            w_state_nxt = BITS;
            w_cnt_nxt   = 3'd0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // Bit sampling: capture SDA at the SCL rise, drop it if START/STOP arrives before the fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= 1'b0;
      r_sample <= 1'b0;
    end else if (w_start || w_stop) begin
      r_pend <= 1'b0;
    end else if (w_scl_rise) begin
      r_pend   <= 1'b1;
      r_sample <= w_sda;
    end else if (w_scl_fall) begin
      r_pend <= 1'b0;
    end
  end

  // SCL-low time while busy; cleared while SCL is high, saturates one past the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_low <= '0;
    end else if (!w_busy || w_scl) begin
      r_low <= '0;
    end else if (r_low != T_SAT) begin
      r_low <= r_low + 1'b1;
    end
  end

  // Error set sources. A glitch only counts while SCL itself is steady high inside a transfer.
  always_comb begin
    w_err_set               = '0;
    w_err_set[ERR_PARTIAL]  = w_partial;
    w_err_set[ERR_TIMEOUT]  = w_busy && !w_scl && (r_low == T_LIM);
    w_err_set[ERR_IDLE_SCL] = w_idle_scl;
    w_err_set[ERR_GLITCH]   = w_sda_glitch && !w_scl_glitch && w_scl && w_busy;
  end

  // Sticky errors; a new set in the same cycle as clear_i survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      r_err <= (clear_i ? '0 : r_err) | w_err_set;
    end
  end

  // Registered event pulses and held data values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start    <= 1'b0;
      r_rstart   <= 1'b0;
      r_stop     <= 1'b0;
      r_bit_vld  <= 1'b0;
      r_bit      <= 1'b0;
      r_byte_vld <= 1'b0;
      r_byte     <= 8'h00;
      r_ack_vld  <= 1'b0;
      r_ack      <= 1'b0;
      r_shift    <= 7'd0;
    end else begin
      r_start    <= w_start_p;
      r_rstart   <= w_rstart_p;
      r_stop     <= w_stop_p;
      r_bit_vld  <= w_bit_p;
      r_byte_vld <= w_byte_p;
      r_ack_vld  <= w_ack_p;
      if (w_bit_p) begin
        r_bit   <= r_sample;
        r_shift <= {r_shift[5:0], r_sample};
      end
      if (w_byte_p) begin
        r_byte <= {r_shift, r_sample};
      end
      if (w_ack_p) begin
        r_ack <= ~r_sample;
      end
    end
  end

  assign busy_o       = w_busy;
  assign start_o      = r_start;
  assign rstart_o     = r_rstart;
  assign stop_o       = r_stop;
  assign bit_valid_o  = r_bit_vld;
  assign bit_o        = r_bit;
  assign byte_valid_o = r_byte_vld;
  assign byte_o       = r_byte;
  assign ack_valid_o  = r_ack_vld;
  assign ack_o        = r_ack;
  assign err_o        = r_err;

endmodule

// File: tb/tb_i2c_bus_checker.sv
// Purpose: directed bench for i2c_bus_checker with an event scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_bus_checker;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_i = 1'b1;
  logic       sda_i = 1'b1;
  logic       clear_i = 1'b0;
  logic       busy_o, start_o, rstart_o, stop_o, bit_valid_o, bit_o;
  logic       byte_valid_o, ack_valid_o, ack_o;
  logic [7:0] byte_o;
  logic [3:0] err_o;

  i2c_bus_checker #(.TIMEOUT_CYCLES(100), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .clear_i      (clear_i),
    .busy_o       (busy_o),
    .start_o      (start_o),
    .rstart_o     (rstart_o),
    .stop_o       (stop_o),
    .bit_valid_o  (bit_valid_o),
    .bit_o        (bit_o),
    .byte_valid_o (byte_valid_o),
    .byte_o       (byte_o),
    .ack_valid_o  (ack_valid_o),
    .ack_o        (ack_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_START, EV_RSTART, EV_STOP, EV_BIT, EV_BYTE, EV_ACK} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] dat;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.dat  = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event_unexpected: got %s/%0h expected nothing", k.name(), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.dat !== d) begin
        n_fail++;
        $display("FAIL event_order: got %s/%0h expected %s/%0h", k.name(), d, e.kind.name(), e.dat);
      end
    end
  endtask

  // Monitor: every pulse the DUT shows is matched against the next expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rstart_o && !start_o) begin
        n_checks++;
        n_fail++;
        $display("FAIL rstart_alone: got rstart_o=1 start_o=0 expected start_o=1");
      end
      if (start_o)      expect_ev(rstart_o ? EV_RSTART : EV_START, 8'h00);
      if (bit_valid_o)  expect_ev(EV_BIT, {7'd0, bit_o});
      if (byte_valid_o) expect_ev(EV_BYTE, byte_o);
      if (ack_valid_o)  expect_ev(EV_ACK, {7'd0, ack_o});
      if (stop_o)       expect_ev(EV_STOP, 8'h00);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start(input bit rep);
    push(rep ? EV_RSTART : EV_START, 8'h00);
    sda_i = 1'b1; cyc(Q);
    scl_i = 1'b1; cyc(Q);
    sda_i = 1'b0; cyc(Q);
    scl_i = 1'b0; cyc(Q);
  endtask

  task automatic bus_bit(input logic b);
    sda_i = b;    cyc(Q);
    scl_i = 1'b1; cyc(2 * Q);
    scl_i = 1'b0; cyc(Q);
  endtask

  task automatic bus_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) begin
      push(EV_BIT, {7'd0, b[i]});
      if (i == 0) push(EV_BYTE, b);
      bus_bit(b[i]);
    end
    push(EV_ACK, {7'd0, ack});
    bus_bit(~ack);
  endtask

  task automatic bus_stop();
    push(EV_STOP, 8'h00);
    sda_i = 1'b0; cyc(Q);
    scl_i = 1'b1; cyc(Q);
    sda_i = 1'b1; cyc(Q);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1; cyc(1);
    clear_i = 1'b0; cyc(2);
  endtask

  initial begin
    logic [4:0] five_bits;
    five_bits = 5'b10110;

    // Reset state.
    cyc(3);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_err", {28'd0, err_o}, 32'd0);
    check("reset_byte", {24'd0, byte_o}, 32'd0);
    check("reset_pulses", {24'd0, start_o, rstart_o, stop_o, bit_valid_o, byte_valid_o,
                           ack_valid_o, bit_o, ack_o}, 32'd0);
    rst_n = 1'b1;
    cyc(4);

    // START, 0xA4, ACK, STOP.
    bus_start(1'b0);
    check("t1_busy_after_start", {31'd0, busy_o}, 32'd1);
    bus_byte(8'hA4, 1'b1);
    bus_stop();
    cyc(4);
    check("t1_err", {28'd0, err_o}, 32'h0);
    check("t1_busy_end", {31'd0, busy_o}, 32'd0);
    check("t1_byte_hold", {24'd0, byte_o}, 32'hA4);

    // 0x3C with NACK, repeated START, 0x81 with ACK, STOP.
    bus_start(1'b0);
    bus_byte(8'h3C, 1'b0);
    check("t2_busy_before_rstart", {31'd0, busy_o}, 32'd1);
    bus_start(1'b1);
    check("t2_busy_after_rstart", {31'd0, busy_o}, 32'd1);
    bus_byte(8'h81, 1'b1);
    bus_stop();
    cyc(4);
    check("t2_err", {28'd0, err_o}, 32'h0);

    // STOP after five data bits.
    bus_start(1'b0);
    for (int i = 4; i >= 0; i--) begin
      push(EV_BIT, {7'd0, five_bits[i]});
      bus_bit(five_bits[i]);
    end
    bus_stop();
    cyc(4);
    check("t3_err_partial", {28'd0, err_o}, 32'h1);
    check("t3_busy", {31'd0, busy_o}, 32'd0);
    pulse_clear();
    check("t3_err_cleared", {28'd0, err_o}, 32'h0);

    // SCL held low after START: limit 100, flag when the low count reaches 101.
    bus_start(1'b0);
    cyc(91);
    check("t4_no_timeout_yet", {28'd0, err_o}, 32'h0);
    cyc(15);
    check("t4_timeout_set", {28'd0, err_o}, 32'h2);
    scl_i = 1'b1;
    cyc(8);
    check("t4_timeout_sticky", {28'd0, err_o}, 32'h2);
    check("t4_busy_kept", {31'd0, busy_o}, 32'd1);
    bus_stop();
    cyc(4);
    check("t4_err_after_stop", {28'd0, err_o}, 32'h2);
    pulse_clear();
    check("t4_err_cleared", {28'd0, err_o}, 32'h0);

    // SCL toggling with no START.
    for (int i = 0; i < 3; i++) begin
      scl_i = 1'b0; cyc(Q);
      scl_i = 1'b1; cyc(Q);
    end
    cyc(4);
    check("t5_err_idle_scl", {28'd0, err_o}, 32'h4);
    check("t5_busy", {31'd0, busy_o}, 32'd0);
    pulse_clear();
    check("t5_err_cleared", {28'd0, err_o}, 32'h0);

    // Reset in the middle of a byte, then a clean 0x5A transfer.
    bus_start(1'b0);
    for (int i = 0; i < 3; i++) begin
      push(EV_BIT, 8'd1);
      bus_bit(1'b1);
    end
    cyc(4);
    check("t6_queue_before_reset", exp_q.size(), 32'd0);
    rst_n = 1'b0;
    scl_i = 1'b1;
    sda_i = 1'b1;
    cyc(3);
    check("t6_reset_busy", {31'd0, busy_o}, 32'd0);
    check("t6_reset_err", {28'd0, err_o}, 32'h0);
    check("t6_reset_byte", {24'd0, byte_o}, 32'h0);
    check("t6_reset_pulses", {24'd0, start_o, rstart_o, stop_o, bit_valid_o, byte_valid_o,
                              ack_valid_o, bit_o, ack_o}, 32'd0);
    rst_n = 1'b1;
    cyc(4);
    bus_start(1'b0);
    bus_byte(8'h5A, 1'b1);
    bus_stop();
    cyc(6);
    check("t6_err", {28'd0, err_o}, 32'h0);
    check("t6_byte", {24'd0, byte_o}, 32'h5A);
    check("t6_busy", {31'd0, busy_o}, 32'd0);

    cyc(10);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
